// File: rtl/xtool_pkg.sv
// Shared helpers for the pulse tools.
//  clogb2 : bits needed to hold the value v (at least 1)
//  xpd_state_e : xpulse_decode FSM encoding
package xtool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } xpd_state_e;

  function automatic int clogb2(input int v);
    int x;
    int r;
    x = v;
    r = 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/xsync.sv
// N-flop level synchronizer, async active-low reset, flops clear to 0.
//  clk, rst_n : clock / reset
//  d          : raw (possibly asynchronous) level
//  q          : synchronized level; q = d combinationally when N = 0
module xsync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (N == 0) begin : g_pass
      assign q = d;
    end else begin : g_sync
      logic [N-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d;
          for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign q = sync_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/xpulse_decode.sv
// Measures the high width of a stretched level pulse.
//  clk, rst_n : clock / async active-low reset
//  i_level    : stretched pulse input (async-safe when Nsync >= 2)
//  o_rise     : 1-clk strobe, measurement started
//  o_pulse    : 1-clk strobe, valid pulse ended (Nmin..Nmax)
//  o_width    : width of last valid pulse, held between o_pulse strobes
//  o_short    : 1-clk strobe, pulse ended below Nmin
//  o_long     : 1-clk strobe, input still high after Nmax clks
//  o_busy     : FSM not idle
module xpulse_decode
  import xtool_pkg::*;
#(
  parameter  int Nmin  = 4,
  parameter  int Nmax  = 16,
  parameter  int Nsync = 2,
  localparam int CW    = clogb2(Nmax)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_level,
  output logic          o_rise,
  output logic          o_pulse,
  output logic [CW-1:0] o_width,
  output logic          o_short,
  output logic          o_long,
  output logic          o_busy
);

  generate
    if (Nmin < 1) begin : g_err_nmin
      $error("xpulse_decode: Nmin must be >= 1");
    end
    if (Nmax < Nmin) begin : g_err_nmax
      $error("xpulse_decode: Nmax must be >= Nmin");
    end
    if (Nsync == 1) begin : g_err_nsync
      $error("xpulse_decode: a single synchronizer stage is not metastability safe");
    end
  endgenerate

  localparam logic [CW-1:0] NMIN_C = CW'(Nmin);
  localparam logic [CW-1:0] NMAX_C = CW'(Nmax);

  logic s_in;

  xsync #(.N(Nsync)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_level),
    .q     (s_in)
  );

  xpd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_d;
  logic          rise_d, pulse_d, short_d, long_d;

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_in) state_d = MEAS;
      MEAS:    if (!s_in) state_d = IDLE;
               else if (cnt_q == NMAX_C) state_d = STUCK;
      STUCK:   if (!s_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // counter and next values of the registered outputs
  always_comb begin
    cnt_d   = cnt_q;
    width_d = o_width;
    rise_d  = 1'b0;
    pulse_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: if (s_in) begin
        cnt_d  = CW'(1);
        rise_d = 1'b1;
      end
      MEAS: begin
        if (s_in) begin
          // cnt saturates at Nmax: the STUCK transition stops it, so no wrap
          if (cnt_q == NMAX_C) long_d = 1'b1;
          else                 cnt_d  = cnt_q + CW'(1);
        end else if (cnt_q >= NMIN_C) begin
          pulse_d = 1'b1;
          width_d = cnt_q;
        end else begin
          short_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_width <= '0;
      o_rise  <= 1'b0;
      o_pulse <= 1'b0;
      o_short <= 1'b0;
      o_long  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_width <= width_d;
      o_rise  <= rise_d;
      o_pulse <= pulse_d;
      o_short <= short_d;
      o_long  <= long_d;
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
